mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the data width.
REQ-002 SHALL have parameter ADDR_W, default 64, the byte address width.
REQ-003 SHALL have parameter MAX_CONSEC, default 4, the maximum consecutive data grants while instruction is pending.
REQ-004 SHALL have parameter TIMEOUT, default 16, the cycles allowed for memory ack before abort.
REQ-005 SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
REQ-006 SHALL have the data (MEM-stage) requester ports:
- d_req  in  1  data request, held until ack/err.
- d_we  in  1  1 = write.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data, valid with d_ack.
- d_ack  out  1  one-cycle completion pulse.
REQ-007 SHALL have the instruction (IF) requester ports:
- i_req  in  1  fetch request, held until ack/err.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data, valid with i_ack.
- i_ack  out  1  one-cycle completion pulse.
REQ-008 SHALL have the memory and status ports:
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid with m_ack.
- m_ack  in  1  memory completion pulse, latency >= 1 cycle.
- err  out  1  one-cycle timeout pulse.
- busy  out  1  high in any BUSY state.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_D, BUSY_I.
REQ-010 In IDLE, SHALL enter BUSY_D when d_req=1 and (i_req=0 or consec<MAX_CONSEC).
REQ-011 In IDLE, SHALL otherwise enter BUSY_I when i_req=1, and stay in IDLE with no request.
REQ-012 On entry to a BUSY state, SHALL register m_addr/m_we/m_wdata from the granted port (i-port: m_we=0, m_wdata=0) and set m_req=1 from the next cycle until exit.
REQ-013 In BUSY_x with m_ack=1, SHALL drive x_ack=1 and x_rdata=m_rdata combinationally in that cycle, then enter IDLE.
REQ-014 Each completed access SHALL cost one IDLE cycle before the next grant, so the minimum back-to-back period is m_ack latency + 1.
REQ-015 The consec counter SHALL increment (saturating at MAX_CONSEC) on a data grant with i_req=1, and clear on an instruction grant or on a data grant with i_req=0.
REQ-016 The timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without m_ack.
REQ-017 When the timeout counter reaches TIMEOUT-1 without m_ack, SHALL pulse err=1 for one cycle, drop m_req, assert no ack, and enter IDLE; the requester retries by keeping req high.
REQ-018 m_ack in IDLE SHALL be ignored (no ack, no err).
REQ-019 m_ack and timeout in the same cycle: ack SHALL win and err stays 0.
REQ-020 A requester deasserting req mid-transaction is illegal; the arbiter SHALL complete the access and still pulse its ack.
REQ-021 d_ack and i_ack SHALL never be high in the same cycle; at most one memory access is outstanding.
REQ-022 When no ack is pulsed, d_rdata and i_rdata SHALL be 0.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, clear consec and timeout counters, and drive m_req, m_we, m_addr, m_wdata, d_ack, i_ack, err, busy to 0.
REQ-024 Reset during BUSY SHALL abandon the access without ack, and any late m_ack after reset SHALL be ignored.
REQ-025 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge.

Verification
REQ-026 Single read: d_req=1, d_we=0, d_addr=0x8, memory acks after 2 cycles with 0x1234 -> m_addr=0x8, d_ack pulses once, d_rdata=0x1234, back to IDLE.
REQ-027 Contention: d_req and i_req both continuously high, m_ack latency 1, MAX_CONSEC=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-028 Write: d_we=1, d_addr=0x400, d_wdata=0x14 -> m_we=1, m_wdata=0x14, d_ack on m_ack, i_ack stays 0.
REQ-029 Timeout: i_req=1 at i_addr=0x0 with m_ack never asserted -> err pulses at cycle 16 of BUSY_I, m_req drops, no i_ack, regrant after one IDLE cycle.
REQ-030 Reset mid-access: rst_n=0 in BUSY_D, then m_ack arrives -> all outputs 0, no d_ack, state IDLE.
REQ-031 Simultaneous m_ack and timeout on the last BUSY cycle -> ack pulses and err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a data (MEM-stage) requester
// and an instruction (IF) requester. Data wins by default, but after
// MAX_CONSEC back-to-back data grants with a fetch waiting, the fetch goes
// next. An access that sees no m_ack within TIMEOUT busy cycles is aborted
// with a one-cycle err pulse, and the requester retries by holding req.
module mem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // instruction requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // memory side and status
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err,
  output logic              busy
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CONSEC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       consec_q, consec_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

  // State and registered memory command.
  // NOTE: the command registers are reset as well, so m_addr/m_wdata read
  // as zero straight out of reset rather than as unknown values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      consec_q  <= '0;
      tmo_q     <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values, whatever the order of these lines.
      state_q   <= state_d;
      consec_q  <= consec_d;
      tmo_q     <= tmo_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // Grant decision, completion/timeout handling and the ack/err outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    consec_d  = consec_q;
    tmo_d     = tmo_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    d_ack     = 1'b0;
    i_ack     = 1'b0;
    d_rdata   = '0;
    i_rdata   = '0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        // m_ack arriving here belongs to no access and is ignored.
        if (d_req && (!i_req || consec_q < MAX_C)) begin
          state_d   = BUSY_D;
          tmo_d     = '0;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req)                consec_d = '0;
          else if (consec_q != MAX_C) consec_d = consec_q + CW'(1);
        end else if (i_req) begin
          state_d   = BUSY_I;
          tmo_d     = '0;
          consec_d  = '0;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (m_ack) begin
          // An ack on the last allowed cycle still completes the access.
          state_d = IDLE;
          if (state_q == BUSY_D) begin
            d_ack   = 1'b1;
            d_rdata = m_rdata;
          end else begin
            i_ack   = 1'b1;
            i_rdata = m_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err     = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign m_req   = busy;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven data transactions, hand-written corner-case
// sequences and a randomized phase, all checked every cycle against a
// transaction-level reference model of the arbiter.
module tb_mem_arbiter;

  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int MAX = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_req, d_we, i_req, m_ack;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] d_rdata, i_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          d_ack, i_ack, m_req, m_we, err, busy;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_CONSEC(MAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  int            mem_cnt   = 0;   // cycles the current access has waited
  int            mem_lat   = 1;   // ack on the mem_lat-th cycle of m_req
  logic          mem_never = 1'b0;
  logic          mem_stray = 1'b0;
  logic          mem_rand  = 1'b0;
  logic [DW-1:0] mem_data  = '0;

  task automatic mem_drive();
    m_ack = (m_req && !mem_never && mem_cnt >= mem_lat - 1) || (!m_req && mem_stray);
    m_rdata = m_ack ? mem_data : {$urandom, $urandom};
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = data port, 2 = instruction port
  int            owner = 0;
  int            age   = 0;     // busy cycles already spent without ack
  int            consec = 0;    // data grants in a row while a fetch waits
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          d_done, i_done, err_seen;
  logic [DW-1:0] cap_rdata, cap_wdata;
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  int            obs_q[$];      // ack order seen on the DUT: 1 = D, 2 = I

  task automatic model_reset();
    owner = 0; age = 0; consec = 0; mem_cnt = 0;
  endtask

  task automatic model_step();
    logic          e_dack, e_iack, e_err;
    logic [DW-1:0] e_drd, e_ird;
    e_dack = (owner == 1) && m_ack;
    e_iack = (owner == 2) && m_ack;
    e_err  = (owner != 0) && !m_ack && (age == TMO - 1);
    e_drd  = e_dack ? m_rdata : '0;
    e_ird  = e_iack ? m_rdata : '0;
    check("busy", busy, owner != 0);
    check("m_req", m_req, owner != 0);
    check("d_ack", d_ack, e_dack);
    check("i_ack", i_ack, e_iack);
    check("err", err, e_err);
    check("d_rdata", d_rdata, e_drd);
    check("i_rdata", i_rdata, e_ird);
    if (owner != 0) begin
      check("m_addr", m_addr, g_addr);
      check("m_we", m_we, g_we);
      check("m_wdata", m_wdata, g_wdata);
    end
    if (d_ack) obs_q.push_back(1);
    if (i_ack) obs_q.push_back(2);
    d_done = e_dack; i_done = e_iack; err_seen = e_err;
    if (e_dack) begin
      cap_rdata = d_rdata; cap_addr = m_addr; cap_we = m_we; cap_wdata = m_wdata;
    end
    // advance the model by one cycle
    if (owner != 0) begin
      if (m_ack || e_err) owner = 0;
      else age++;
    end else if (d_req && (!i_req || consec < MAX)) begin
      owner = 1; age = 0;
      g_we = d_we; g_addr = d_addr; g_wdata = d_wdata;
      consec = i_req ? ((consec + 1 > MAX) ? MAX : consec + 1) : 0;
    end else if (i_req) begin
      owner = 2; age = 0;
      g_we = 1'b0; g_addr = i_addr; g_wdata = '0;
      consec = 0;
    end
    // memory environment bookkeeping
    if (m_req && !m_ack) mem_cnt++;
    else begin
      mem_cnt = 0;
      if (mem_rand) mem_lat = $urandom_range(18, 1);
    end
  endtask

  // One clock cycle: inputs are already set; memory responds, outputs are
  // checked mid-cycle, then the clock edge is taken.
  task automatic cyc();
    mem_drive();
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".m_req"}, m_req, 0);
    check({tag, ".m_we"}, m_we, 0);
    check({tag, ".m_addr"}, m_addr, 0);
    check({tag, ".m_wdata"}, m_wdata, 0);
    check({tag, ".d_ack"}, d_ack, 0);
    check({tag, ".i_ack"}, i_ack, 0);
    check({tag, ".err"}, err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ack = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- data transaction table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_we;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_dack, n_iack, busy_cycles, err_at, k;
    int pat[10];

    vecs[0] = '{1'b0, 64'h8, 64'h0, 64'h1234, 2, 64'h1234, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 64'h400, 64'h14, 64'hdead, 1, 64'hdead, 1'b1, 64'h14};
    vecs[2] = '{1'b0, 64'hffff_ffff_ffff_fff8, 64'h0, '1, 3, '1, 1'b0, 64'h0};
    vecs[3] = '{1'b1, 64'h0, '1, 64'h77, 5, 64'h77, 1'b1, '1};
    vecs[4] = '{1'b0, 64'h100, 64'h0, 64'h55, TMO, 64'h55, 1'b0, 64'h0};
    pat = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_addr = '0; m_rdata = '0;
    rst_n = 1'b0; m_ack = 1'b0;
    #1;
    check_all_zero("reset");
    do_reset();
    check_all_zero("post_reset");

    // --- table-driven data accesses (read, write, corners, ack on last cycle)
    foreach (vecs[v]) begin
      d_req = 1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      mem_lat = vecs[v].lat; mem_data = vecs[v].rdata;
      n_dack = 0; n_iack = 0; err_at = 0;
      for (int c = 0; c < 40 && n_dack == 0; c++) begin
        cyc();
        if (d_done) n_dack++;
        if (err_seen) err_at++;
      end
      d_req = 0;
      for (int c = 0; c < 3; c++) begin
        cyc();
        if (d_done) n_dack++;
        if (i_done) n_iack++;
      end
      check($sformatf("vec%0d.d_ack_count", v), n_dack, 1);
      check($sformatf("vec%0d.i_ack_count", v), n_iack, 0);
      check($sformatf("vec%0d.err_count", v), err_at, 0);
      check($sformatf("vec%0d.d_rdata", v), cap_rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d.m_addr", v), cap_addr, vecs[v].addr);
      check($sformatf("vec%0d.m_we", v), cap_we, vecs[v].exp_we);
      check($sformatf("vec%0d.m_wdata", v), cap_wdata, vecs[v].exp_wdata);
    end

    // --- contention: both requesting continuously, latency 1
    do_reset();
    obs_q.delete();
    d_req = 1; d_we = 0; d_addr = 64'h40; i_req = 1; i_addr = 64'h80;
    mem_lat = 1; mem_data = 64'habc;
    for (int c = 0; c < 60 && obs_q.size() < 10; c++) cyc();
    check("contention.grant_count", obs_q.size(), 10);
    for (int g = 0; g < 10 && g < obs_q.size(); g++)
      check($sformatf("contention.grant%0d", g), obs_q[g], pat[g]);
    d_req = 0; i_req = 0;
    cyc(); cyc();

    // --- timeout on a fetch, then regrant after one idle cycle
    i_req = 1; i_addr = 64'h0; mem_never = 1;
    busy_cycles = 0; err_at = 0;
    for (int c = 0; c < 40 && err_at == 0; c++) begin
      if (busy) busy_cycles++;
      cyc();
      if (err_seen) err_at = busy_cycles;
    end
    check("timeout.err_cycle", err_at, TMO);
    check("timeout.idle_after_err", busy, 0);
    cyc();
    check("timeout.regrant", busy, 1);
    mem_never = 0; mem_lat = 1; mem_data = 64'hf00d;
    n_iack = 0;
    for (int c = 0; c < 5 && n_iack == 0; c++) begin
      cyc();
      if (i_done) n_iack++;
    end
    check("timeout.retry_ack", n_iack, 1);
    i_req = 0;
    cyc();

    // --- reset in the middle of a data access, then a late m_ack
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'h99; mem_lat = 10;
    cyc(); cyc();
    check("midreset.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    m_ack = 1'b1; m_rdata = 64'h1111;
    #1;
    check("midreset.late_d_ack", d_ack, 0);
    check("midreset.late_err", err, 0);
    d_req = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset.state_idle", busy, 0);
    mem_stray = 1;
    cyc(); cyc();
    mem_stray = 0;

    // --- randomized traffic
    mem_rand = 1;
    for (int c = 0; c < 600; c++) begin
      if (!d_req && $urandom_range(3, 0) == 0) begin
        d_req = 1; d_we = $urandom_range(1, 0);
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      end
      if (!i_req && $urandom_range(3, 0) == 0) begin
        i_req = 1; i_addr = {$urandom, $urandom};
      end
      mem_stray = ($urandom_range(9, 0) == 0);
      mem_data  = {$urandom, $urandom};
      cyc();
      if (d_done) d_req = 0;
      if (i_done) i_req = 0;
    end
    mem_rand = 0; mem_stray = 0; d_req = 0; i_req = 0;
    k = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      cyc();
      k++;
    end
    check("final.idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
